ifetch_prefetch: RTL and testbench

//  Instruction-side wishbone master between the mp3 fetch stage and instruction_memory_wishbone.

---
 rtl/ifetch_pkg.sv | 19 +
 rtl/ifetch_line_fifo.sv | 61 ++++++
 rtl/ifetch_prefetch.sv | 139 +++++++++++++
 tb/tb_ifetch_prefetch.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction prefetcher.
package ifetch_pkg;

  localparam int LINE_WORDS = 8;

  typedef logic [255:0] line_t;
  typedef logic [26:0]  line_addr_t;
  typedef logic [2:0]   word_off_t;

  typedef logic [1:0] ifetch_state_e;
  localparam ifetch_state_e IDLE  = 2'd0;
  localparam ifetch_state_e BUSY  = 2'd1;
  localparam ifetch_state_e DRAIN = 2'd2;

  function automatic logic [31:0] line_word(input line_t line, input word_off_t off);
    return line[32*off +: 32];
  endfunction

endpackage

// File: rtl/ifetch_line_fifo.sv
// Line buffer: DEPTH entries of {line address, 256-bit line}, with synchronous flush.
// Latency: a pushed line is at the head the cycle after the push edge.
// Backpressure: none internally; the caller guarantees no push when full and no pop when empty.
module ifetch_line_fifo
  import ifetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  line_addr_t    push_addr,
  input  line_t         push_line,
  input  logic          pop,
  input  logic          flush,
  output logic [CW-1:0] count,
  output line_addr_t    head_addr,
  output line_t         head_line
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  line_addr_t    addr_mem [DEPTH];
  line_t         line_mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage carries no reset; only the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      addr_mem[wr_ptr] <= push_addr;
      line_mem[wr_ptr] <= push_line;
    end
  end

  assign head_addr = addr_mem[rd_ptr];
  assign head_line = line_mem[rd_ptr];

endmodule

// File: rtl/ifetch_prefetch.sv
// Wishbone line prefetcher feeding 32-bit words to fetch; IFETCH_BYPASS_EN forwards the ack line in its own cycle.
// Latency: request visible the cycle after IDLE, word valid the cycle after ack (ack cycle with bypass).
// Backpressure: new requests only while buffered + outstanding lines < DEPTH; fetch stalls via instr_ready.
module ifetch_prefetch
  import ifetch_pkg::*;
#(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0060
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         redirect_valid,
  input  logic [31:0]  redirect_pc,
  output logic         instr_valid,
  input  logic         instr_ready,
  output logic [31:0]  instr_pc,
  output logic [31:0]  instr,
  output logic         wb_cyc,
  output logic         wb_stb,
  output logic         wb_we,
  output logic [31:0]  wb_sel,
  output logic [26:0]  wb_adr,
  input  logic [255:0] wb_dat_s,
  input  logic         wb_ack
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

  ifetch_state_e state;
  logic          cyc_q;
  line_addr_t    adr_q;
  line_addr_t    next_line;
  word_off_t     word_off;

  logic [CW-1:0] count;
  logic [CW:0]   count_ext;
  logic [CW:0]   count_next;
  line_addr_t    head_addr;
  line_t         head_line;

  logic ack_keep, bypass, hs, last_word, fifo_pop, push;
  logic unused_pc_bits;

  assign unused_pc_bits = &{1'b0, redirect_pc[1:0]};

  assign ack_keep  = (state == BUSY) && wb_ack && !redirect_valid;
  assign hs        = instr_valid && instr_ready && !redirect_valid;
  assign last_word = hs && (word_off == word_off_t'(LINE_WORDS - 1));
  assign fifo_pop  = last_word && (count != '0);
  // A bypassed line fully consumed in its ack cycle never needs a buffer slot.
  assign push      = ack_keep && !(bypass && last_word);

  assign count_ext  = {1'b0, count};
  assign count_next = count_ext + (CW + 1)'(push) - (CW + 1)'(fifo_pop);

`ifdef IFETCH_BYPASS_EN
  assign bypass      = ack_keep && (count == '0);
  assign instr_valid = (count != '0) || bypass;
  assign instr       = bypass ? line_word(wb_dat_s, word_off) : line_word(head_line, word_off);
  assign instr_pc    = {(bypass ? adr_q : head_addr), word_off, 2'b00};
`else
  assign bypass      = 1'b0;
  assign instr_valid = (count != '0);
  assign instr       = line_word(head_line, word_off);
  assign instr_pc    = {head_addr, word_off, 2'b00};
`endif

  ifetch_line_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_addr (adr_q),
    .push_line (wb_dat_s),
    .pop       (fifo_pop),
    .flush     (redirect_valid),
    .count     (count),
    .head_addr (head_addr),
    .head_line (head_line)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cyc_q     <= 1'b0;
      adr_q     <= RESET_PC[31:5];
      next_line <= RESET_PC[31:5];
      word_off  <= RESET_PC[4:2];
    end else begin
      case (state)
        IDLE: begin
          if (!redirect_valid && (count_ext < DEPTH_C)) begin
            state <= BUSY;
            cyc_q <= 1'b1;
            adr_q <= next_line;
          end
        end
        BUSY: begin
          if (wb_ack) begin
            // Chain the next request only if the just-acked line leaves room for it.
            if (!redirect_valid && (count_next < DEPTH_C)) begin
              adr_q <= next_line + 1'b1;
            end else begin
              state <= IDLE;
              cyc_q <= 1'b0;
            end
          end else if (redirect_valid) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (wb_ack) begin
            state <= IDLE;
            cyc_q <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          cyc_q <= 1'b0;
        end
      endcase

      if (redirect_valid) begin
        next_line <= redirect_pc[31:5];
        word_off  <= redirect_pc[4:2];
      end else begin
        if (ack_keep) next_line <= next_line + 1'b1;
        if (hs)       word_off  <= word_off + 1'b1;
      end
    end
  end

  assign wb_cyc = cyc_q;
  assign wb_stb = cyc_q;
  assign wb_we  = 1'b0;
  assign wb_sel = '1;
  assign wb_adr = adr_q;

endmodule

// File: tb/tb_ifetch_prefetch.sv
// Bench for ifetch_prefetch: directed scenarios then random traffic against a PC-sequence reference model.
module tb_ifetch_prefetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0060;

  logic         clk = 1'b0;
  logic         rst;
  logic         redirect_valid;
  logic [31:0]  redirect_pc;
  logic         instr_valid;
  logic         instr_ready;
  logic [31:0]  instr_pc;
  logic [31:0]  instr;
  logic         wb_cyc, wb_stb, wb_we;
  logic [31:0]  wb_sel;
  logic [26:0]  wb_adr;
  logic [255:0] wb_dat_s;
  logic         wb_ack;

  logic slave_en, ack_now;
  int   ack_delay, wait_cnt;

  int   total = 0, passed = 0;
  int   hs_cnt = 0;
  logic [31:0] exp_pc, last_pc;
  logic [26:0] ack_adrs [$];

  always #5 clk = ~clk;

  ifetch_prefetch #(.DEPTH(2), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_pc(instr_pc), .instr(instr),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_sel(wb_sel),
    .wb_adr(wb_adr), .wb_dat_s(wb_dat_s), .wb_ack(wb_ack)
  );

  // Memory contents: every byte address maps to a distinct scrambled word.
  function automatic logic [31:0] memfn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  function automatic logic [255:0] mk_line(input logic [26:0] adr);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) begin
      logic [2:0] wi;
      wi = 3'(i);
      l[32*i +: 32] = memfn({adr, wi, 2'b00});
    end
    return l;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic sample(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic wait_cyc(input logic v, input string tag);
    int i = 0;
    while (wb_cyc !== v && i < 100) begin sample(1); i++; end
    chk(tag, wb_cyc, v);
  endtask

  task automatic wait_ack(input string tag);
    int i = 0;
    while (wb_ack !== 1'b1 && i < 100) begin sample(1); i++; end
    chk(tag, wb_ack, 1'b1);
  endtask

  task automatic wait_valid(input string tag);
    int i = 0;
    while (instr_valid !== 1'b1 && i < 100) begin sample(1); i++; end
    chk(tag, instr_valid, 1'b1);
  endtask

  // Wishbone slave: acks after ack_delay idle cycles, or at once when ack_now is set.
  initial begin
    wb_ack = 1'b0; wb_dat_s = '0; wait_cnt = 0;
    forever begin
      @(posedge clk); #2;
      if (wb_ack) begin
        wb_ack = 1'b0; wait_cnt = 0;
      end else if (wb_cyc && (ack_now || (slave_en && wait_cnt >= ack_delay))) begin
        wb_ack = 1'b1; wb_dat_s = mk_line(wb_adr);
      end else if (wb_cyc && slave_en) begin
        wait_cnt++;
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Reference model: fetch delivers consecutive word addresses, restarting at each redirect.
  initial begin
    exp_pc = RESET_PC; last_pc = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_pc = RESET_PC;
      end else begin
        if (wb_ack) ack_adrs.push_back(wb_adr);
        if (redirect_valid) begin
          exp_pc = {redirect_pc[31:2], 2'b00};
        end else if (instr_valid && instr_ready) begin
          chk("stream_pc", instr_pc, exp_pc);
          chk("stream_instr", instr, memfn(exp_pc));
          last_pc = exp_pc;
          exp_pc  = exp_pc + 32'd4;
          hs_cnt++;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base, hs0, found;
    rst = 1'b1; instr_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    slave_en = 1'b1; ack_now = 1'b0; ack_delay = 2;

    // Reset state
    sample(3);
    chk("rst_cyc", wb_cyc, 0);
    chk("rst_stb", wb_stb, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_adr", wb_adr, 27'h3);
    chk("rst_we", wb_we, 0);
    chk("rst_sel", wb_sel, 32'hFFFF_FFFF);

    // First line and its latency
    step(); rst = 1'b0;
    base = ack_adrs.size();
    wait_cyc(1'b1, "t1_req");
    chk("t1_adr", wb_adr, 27'h3);
    chk("t1_stb", wb_stb, 1);
    wait_ack("t1_ack");
`ifdef IFETCH_BYPASS_EN
    chk("t1_bypass_valid", instr_valid, 1);
    chk("t1_bypass_pc", instr_pc, RESET_PC);
    chk("t1_bypass_instr", instr, memfn(RESET_PC));
`else
    chk("t1_ack_cycle_valid", instr_valid, 0);
`endif
    sample(1);
    chk("t1_valid", instr_valid, 1);
    chk("t1_pc", instr_pc, RESET_PC);
    chk("t1_instr", instr, memfn(RESET_PC));

    // Stalled fetch: exactly DEPTH lines requested, then the bus goes quiet
    sample(40);
    chk("t2_nreq", ack_adrs.size() - base, 2);
    chk("t2_adr0", ack_adrs[base], 27'h3);
    chk("t2_adr1", ack_adrs[base + 1], 27'h4);
    chk("t2_idle", wb_cyc, 0);
    step(); instr_ready = 1'b1;
    hs0 = hs_cnt;
    sample(60);
    chk("t2_resume", (hs_cnt - hs0) >= 16, 1);

    // Redirect while a request is outstanding: its data must be dropped
    step(); slave_en = 1'b0;
    sample(30);
    chk("t3_busy", wb_cyc, 1);
    chk("t3_empty", instr_valid, 0);
    step(); redirect_valid = 1'b1; redirect_pc = 32'h0000_1004;
    step(); redirect_valid = 1'b0;
    sample(1);
    chk("t3_drain_cyc", wb_cyc, 1);
    slave_en = 1'b1; ack_delay = 1;
    wait_ack("t3_drain_ack");
    chk("t3_drain_novalid", instr_valid, 0);
    wait_cyc(1'b0, "t3_idle");
    wait_cyc(1'b1, "t3_req");
    chk("t3_adr", wb_adr, 27'h80);
    wait_valid("t3_valid");
    chk("t3_pc", instr_pc, 32'h0000_1004);
    chk("t3_instr", instr, memfn(32'h0000_1004));

    // Redirect coinciding with ack: line dropped, no stale word, immediate refetch
    step(); instr_ready = 1'b0; slave_en = 1'b1; ack_delay = 0;
    sample(30);
    chk("t4_full_idle", wb_cyc, 0);
    chk("t4_full_valid", instr_valid, 1);
    step(); instr_ready = 1'b1; slave_en = 1'b0;
    wait_cyc(1'b1, "t4_busy");
    step(); instr_ready = 1'b0; ack_now = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'h0000_2000;
    step(); ack_now = 1'b0; redirect_valid = 1'b0;
    sample(1);
    chk("t4_cyc_idle", wb_cyc, 0);
    chk("t4_no_stale", instr_valid, 0);
    sample(1);
    chk("t4_req", wb_cyc, 1);
    chk("t4_adr", wb_adr, 27'h100);
    slave_en = 1'b1; ack_delay = 1;

    // Address wrap at the top of memory
    step(); instr_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFE0;
    step(); redirect_valid = 1'b0;
    hs0 = hs_cnt; base = ack_adrs.size();
    for (int i = 0; i < 300 && hs_cnt < hs0 + 9; i++) sample(1);
    chk("t5_nwords", hs_cnt - hs0, 9);
    chk("t5_wrap_pc", last_pc, 32'h0);
    found = 0;
    for (int i = base; i + 1 < ack_adrs.size(); i++)
      if (found == 0 && ack_adrs[i] == 27'h7FF_FFFF) found = (ack_adrs[i + 1] == 27'h0) ? 1 : 2;
    chk("t5_adr_wrap", found, 1);

    // Asynchronous reset between edges while a request is on the bus
    step(); slave_en = 1'b0;
    wait_cyc(1'b1, "t6_busy");
    @(negedge clk); #2; rst = 1'b1;
    #1;
    chk("t6_async_cyc", wb_cyc, 0);
    chk("t6_async_stb", wb_stb, 0);
    chk("t6_async_valid", instr_valid, 0);
    step(); step(); rst = 1'b0; instr_ready = 1'b0; slave_en = 1'b1; ack_delay = 1;
    wait_cyc(1'b1, "t6_req");
    chk("t6_adr", wb_adr, 27'h3);
    wait_ack("t6_ack");
`ifdef IFETCH_BYPASS_EN
    chk("t6_bypass_valid", instr_valid, 1);
    chk("t6_bypass_instr", instr, memfn(RESET_PC));
`else
    chk("t6_ack_cycle_valid", instr_valid, 0);
`endif
    sample(1);
    chk("t6_valid", instr_valid, 1);
    chk("t6_pc", instr_pc, RESET_PC);

    // Random traffic, checked by the stream model
    hs0 = hs_cnt;
    for (int c = 0; c < 3000; c++) begin
      step();
      instr_ready    = ($urandom_range(0, 3) != 0);
      ack_delay      = $urandom_range(0, 3);
      redirect_valid = ($urandom_range(0, 39) == 0);
      if (redirect_valid)
        redirect_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFC0 | ($urandom & 32'h3F)) : $urandom;
    end
    step(); redirect_valid = 1'b0; instr_ready = 1'b1;
    sample(50);
    chk("rand_progress", (hs_cnt - hs0) > 500, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
